// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide controller: op codes, FSM states,
// iteration count and a magnitude helper.
package muldiv_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } md_state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: 64-bit accumulator doing one shift-add (multiply) or
// one restoring subtract (divide) step per enabled cycle on unsigned operands.
module muldiv_core
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        is_div_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  output logic [63:0] acc_o
);

  logic [63:0] acc_q, acc_d;
  logic [31:0] m_q, m_d;
  logic [32:0] add_sum;
  logic [33:0] sub_diff;

  always_comb begin
    add_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
    // 34-bit trial keeps the borrow valid when the shifted remainder exceeds 32 bits
    sub_diff = {1'b0, acc_q[63:31]} - {2'b00, m_q};
    acc_d    = acc_q;
    m_d      = m_q;
    if (load_i) begin
      acc_d = {32'd0, is_div_i ? opa_i : opb_i};
      m_d   = is_div_i ? opb_i : opa_i;
    end else if (step_i) begin
      if (is_div_i) begin
        acc_d = sub_diff[33] ? {acc_q[62:0], 1'b0}
                             : {sub_diff[31:0], acc_q[30:0], 1'b1};
      end else begin
        acc_d = {add_sum, acc_q[31:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      m_q   <= '0;
    end else begin
      acc_q <= acc_d;
      m_q   <= m_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide unit control: sequencing FSM, iteration down-counter,
// sign handling and the HI/LO architectural registers.
//
// state | meaning
// IDLE  | waiting for start_i; mthi/mtlo writes land here
// RUN   | one core iteration per cycle, cnt_q counts 31 down to 0
// DONE  | sign-correct result, commit HI/LO on the exiting edge
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        hilo_rd_id_i,
  input  logic        hilo_we_i,
  input  logic        hilo_sel_i,
  input  logic [31:0] hilo_wdata_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;

  logic             load;
  logic             is_signed;
  logic             div_zero;
  logic [31:0]      opa, opb;
  logic [63:0]      acc;
  logic [31:0]      res_hi, res_lo;
  logic [63:0]      prod;

  muldiv_core u_core (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .step_i   (state_q == RUN),
    .is_div_i (is_div_d),
    .opa_i    (opa),
    .opb_i    (opb),
    .acc_o    (acc)
  );

  // Divide by zero runs unsigned on raw operands: the core then yields
  // quotient all-ones and remainder equal to the dividend with no correction.
  always_comb begin
    is_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
    div_zero  = op_i[1] && (b_i == 32'd0);
    opa       = (is_signed && !div_zero) ? abs32(a_i) : a_i;
    opb       = (is_signed && !div_zero) ? abs32(b_i) : b_i;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          load      = 1'b1;
          state_d   = RUN;
          cnt_d     = CNT_W'(ITER - 1);
          is_div_d  = op_i[1];
          neg_d     = is_signed && !div_zero && (a_i[31] ^ b_i[31]);
          rem_neg_d = is_signed && !div_zero && a_i[31];
        end
      end
      RUN: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prod   = neg_q ? (64'd0 - acc) : acc;
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (is_div_q) begin
      res_lo = neg_q     ? (32'd0 - acc[31:0])  : acc[31:0];
      res_hi = rem_neg_q ? (32'd0 - acc[63:32]) : acc[63:32];
    end
  end

  // A completing operation overrides a coincident mthi/mtlo on both registers
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == DONE) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end else if (hilo_we_i) begin
      if (hilo_sel_i) hi_d = hilo_wdata_i;
      else            lo_d = hilo_wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign stall_o = busy_o && (hilo_rd_id_i || start_i);
  assign done_o  = (state_q == DONE);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule
